// File: rtl/lock_code_driver.sv
// lock_code_driver: initiator side of the combination-lock keypad interface.
// Latches an N-digit code on Start, strobes each digit into the lock with a
// one-cycle Enter followed by an idle gap, then waits for LockOpen/LockFail
// (or a timeout) and reports the outcome on Result with a one-cycle Done.
// Optional feature macro: LOCK_DRV_AUTO_RESET_EN adds a RELOCK state that
// pulses LockReset for one cycle after every attempt.
module lock_code_driver #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned GAP_CYCLES = 3,
    parameter int unsigned WAIT_MAX   = 15
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] Code,
    output logic                          Enter,
    output logic [DIGIT_W-1:0]            Digit,
    input  logic                          LockOpen,
    input  logic                          LockFail,
    output logic                          Busy,
    output logic                          Done,
    output logic [1:0]                    Result,
    output logic                          LockReset
);

    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_OPEN    = 2'b01;
    localparam logic [1:0] RES_FAIL    = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StGap,
        StWait,
        StDone
`ifdef LOCK_DRV_AUTO_RESET_EN
        ,
        StRelock
`endif
    } state_e;

    state_e                                 state_q, state_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     code_q, code_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [GAP_W-1:0]                       gap_q, gap_d;
    logic [WAIT_W-1:0]                      wait_q, wait_d;
    logic [DIGIT_W-1:0]                     digit_q, digit_d;
    logic [1:0]                             result_q, result_d;

    // State and datapath registers; reset aborts any attempt silently.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            code_q   <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            wait_q   <= '0;
            digit_q  <= '0;
            result_q <= RES_NONE;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            wait_q   <= wait_d;
            digit_q  <= digit_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: digit sequencing, gap timing and outcome capture.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        wait_d   = wait_q;
        digit_d  = digit_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    code_d   = Code;
                    result_d = RES_NONE;
                    idx_d    = '0;
                    gap_d    = '0;
                    wait_d   = '0;
                    // Digit is registered so it is already valid during the Enter cycle.
                    digit_d  = code_d[0];
                    state_d  = StSend;
                end
            end
            StSend: begin
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (idx_q == LAST_IDX) begin
                        wait_d  = '0;
                        state_d = StWait;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        digit_d = code_q[idx_d];
                        state_d = StSend;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StWait: begin
                // Fail has priority over Open when both are asserted together.
                if (LockFail) begin
                    result_d = RES_FAIL;
                    state_d  = StDone;
                end else if (LockOpen) begin
                    result_d = RES_OPEN;
                    state_d  = StDone;
                end else if (wait_q == WAIT_LAST) begin
                    result_d = RES_TIMEOUT;
                    state_d  = StDone;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDone: begin
`ifdef LOCK_DRV_AUTO_RESET_EN
                state_d = StRelock;
`else
                state_d = StIdle;
`endif
            end
`ifdef LOCK_DRV_AUTO_RESET_EN
            StRelock: begin
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign Enter  = (state_q == StSend);
    assign Digit  = digit_q;
    assign Busy   = (state_q != StIdle);
    assign Done   = (state_q == StDone);
    assign Result = result_q;

`ifdef LOCK_DRV_AUTO_RESET_EN
    assign LockReset = (state_q == StRelock);
`else
    assign LockReset = 1'b0;
`endif

endmodule

// File: tb/tb_lock_code_driver.sv
// Self-checking bench for lock_code_driver: randomized attempts against a
// cycle-timed reference model; expected Enter/Done events go into queues and
// a negedge monitor pops and compares them as the DUT presents them.
module tb_lock_code_driver;

    localparam int N  = 2;
    localparam int DW = 4;
    localparam int G  = 3;
    localparam int WM = 15;
    localparam int CW = N * DW;
`ifdef LOCK_DRV_AUTO_RESET_EN
    localparam int RELOCK = 1;
`else
    localparam int RELOCK = 0;
`endif

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic [CW-1:0] Code;
    logic          Enter;
    logic [DW-1:0] Digit;
    logic          LockOpen;
    logic          LockFail;
    logic          Busy;
    logic          Done;
    logic [1:0]    Result;
    logic          LockReset;

    lock_code_driver #(
        .NUM_DIGITS (N),
        .DIGIT_W    (DW),
        .GAP_CYCLES (G),
        .WAIT_MAX   (WM)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Code      (Code),
        .Enter     (Enter),
        .Digit     (Digit),
        .LockOpen  (LockOpen),
        .LockFail  (LockFail),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .LockReset (LockReset)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } enter_t;
    typedef struct {
        int         c;
        logic [1:0] r;
    } done_t;

    enter_t enter_q[$];
    done_t  done_q[$];

    int checks = 0;
    int errors = 0;

    // Window of the attempt currently being modelled (cycle numbers).
    int         cur_s    = -100;
    int         cur_done = -100;
    int         cur_end  = -100;
    logic [1:0] prev_res = 2'b00;
    logic [1:0] cur_res  = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops expected events when the DUT presents them, checks status each cycle.
    always @(negedge Clock) begin : monitor
        enter_t     e;
        done_t      d;
        logic [1:0] er;
        logic       lr;
        if (Enter) begin
            if (enter_q.size() == 0) begin
                check("enter_unexpected", 32'd1, 32'd0);
            end else begin
                e = enter_q.pop_front();
                check("enter_cycle", cyc, e.c);
                check("enter_digit", 32'(Digit), 32'(e.d));
            end
        end
        if (Done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                d = done_q.pop_front();
                check("done_cycle", cyc, d.c);
                check("done_result", 32'(Result), 32'(d.r));
            end
        end
        check("busy", 32'(Busy), 32'(cyc > cur_s && cyc <= cur_end));
        if (cyc > cur_s && cyc < cur_done) er = 2'b00;
        else if (cyc >= cur_done)          er = cur_res;
        else                               er = prev_res;
        check("result_level", 32'(Result), 32'(er));
        lr = (RELOCK == 1) && (cyc == cur_done + 1);
        check("lock_reset", 32'(LockReset), 32'(lr));
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One attempt starting in the current (IDLE) window; returns in the last Busy window.
    // mode: 0 open, 1 fail, 2 both, 3 timeout; w = WAIT cycle of the indication.
    task automatic attempt(input int mode, input int w, input logic [CW-1:0] code,
                           input bit noise);
        int         s;
        int         went;
        int         dc;
        logic [1:0] r;
        Start = 1'b1;
        Code  = code;
        s     = cyc;
        went  = s + N * (G + 1) + 1;
        if (mode == 3) w = WM - 1;
        dc = went + w + 1;
        case (mode)
            0:       r = 2'b01;
            1, 2:    r = 2'b10;
            default: r = 2'b11;
        endcase
        for (int k = 0; k < N; k++)
            enter_q.push_back(enter_t'{c: s + 1 + k * (G + 1), d: code[k*DW +: DW]});
        done_q.push_back(done_t'{c: dc, r: r});
        prev_res = cur_res;
        cur_res  = r;
        cur_s    = s;
        cur_done = dc;
        cur_end  = dc + RELOCK;
        for (int c = s + 1; c <= dc; c++) begin
            step();
            Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) Code = CW'($urandom);
            if (c < went) begin
                LockOpen = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                LockFail = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (c < went + w) begin
                LockOpen = 1'b0;
                LockFail = 1'b0;
            end else begin
                LockOpen = (mode == 0 || mode == 2);
                LockFail = (mode == 1 || mode == 2);
            end
        end
        Start    = 1'b0;
        LockOpen = 1'b0;
        LockFail = 1'b0;
        repeat (RELOCK) step();
    endtask

    // early: Start raised during the last Busy window and held into IDLE.
    task automatic next_attempt(input int mode, input int w, input logic [CW-1:0] code,
                                input bit noise, input bit early, input int gap);
        if (early) begin
            Start = 1'b1;
            step();
        end else begin
            step();
            repeat (gap) step();
        end
        attempt(mode, w, code, noise);
    endtask

    task automatic reset_mid_attempt();
        int s;
        step();
        Start = 1'b1;
        Code  = 8'h32;
        s     = cyc;
        enter_q.push_back(enter_t'{c: s + 1, d: 4'h2});
        enter_q.push_back(enter_t'{c: s + 5, d: 4'h3});
        prev_res = cur_res;
        cur_res  = 2'b00;
        cur_s    = s;
        cur_done = s + 1000;
        cur_end  = s + 1000;
        step();
        Start = 1'b0;
        repeat (5) step();
        Reset    = 1'b1;
        cur_s    = -100;
        cur_done = -100;
        cur_end  = -100;
        prev_res = 2'b00;
        cur_res  = 2'b00;
        #1;
        check("rst_enter", 32'(Enter), 32'd0);
        check("rst_digit", 32'(Digit), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_lockreset", 32'(LockReset), 32'd0);
        check("rst_enter_pending", enter_q.size(), 32'd0);
        #1;
        Reset = 1'b0;
        step();
        attempt(0, 2, 8'hA7, 1'b0);
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Code     = '0;
        LockOpen = 1'b0;
        LockFail = 1'b0;
        repeat (2) step();
        check("init_enter", 32'(Enter), 32'd0);
        check("init_digit", 32'(Digit), 32'd0);
        check("init_busy", 32'(Busy), 32'd0);
        check("init_done", 32'(Done), 32'd0);
        check("init_result", 32'(Result), 32'd0);
        check("init_lockreset", 32'(LockReset), 32'd0);
        Reset = 1'b0;
        step();

        next_attempt(0, 0, 8'h32, 1'b0, 1'b0, 0);
        next_attempt(1, 0, 8'h52, 1'b1, 1'b0, 1);
        next_attempt(2, 3, 8'h9C, 1'b0, 1'b0, 0);
        next_attempt(3, 0, 8'h41, 1'b0, 1'b0, 2);
        reset_mid_attempt();
        next_attempt(0, 5, 8'h6E, 1'b1, 1'b0, 0);
        next_attempt(1, 1, 8'hF0, 1'b0, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            next_attempt(int'($urandom_range(0, 3)), int'($urandom_range(0, WM - 1)),
                         CW'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        step();
        repeat (5) step();
        check("enter_queue_drained", enter_q.size(), 32'd0);
        check("done_queue_drained", done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
